core_bus_arbiter: RTL

Two-port arbiter that shares the single core memory bus between the instruction-fetch port and the EX/MEM data port. It registers the winning request, drives the bus until the memory responds, and routes the response and read data back to the owner. Data has priority, with a starvation guard for fetch. A lock input keeps multi-access data sequences (unaligned and sub-word read-modify-write) atomic. A timeout returns an error instead of hanging the pipeline.

---
 rtl/core_bus_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares the core memory bus between fetch and data ports
module core_bus_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_read_i,
  input  logic [31:0] instr_address_i,
  output logic        instr_response_o,
  output logic [31:0] instr_read_data_o,
  output logic        instr_error_o,
  input  logic        data_read_i,
  input  logic        data_write_i,
  input  logic [31:0] data_address_i,
  input  logic [31:0] data_write_data_i,
  input  logic        data_lock_i,
  output logic        data_response_o,
  output logic [31:0] data_read_data_o,
  output logic        data_error_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  input  logic [31:0] mem_read_data_i,
  input  logic        mem_response_i,
  output logic [1:0]  grant_o
);
  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GRANT_INSTR, GRANT_DATA, LOCK_WAIT} state_e;
  state_e state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic we_q, we_d;
  logic data_req, fetch_force, in_grant, tmo_fire, done, go_data, go_instr;
  // arbitration decisions and completion/timeout detection for this cycle
  always_comb begin
    data_req = data_read_i | data_write_i;
    fetch_force = instr_read_i && (burst_q >= BURST_MAX);
    in_grant = (state_q == GRANT_INSTR) || (state_q == GRANT_DATA);
    tmo_fire = (TIMEOUT_CYCLES != 0) && in_grant && !mem_response_i && (tmo_q == TMO_LAST);
    done = in_grant && (mem_response_i || tmo_fire);
    go_data = ((state_q == IDLE) && data_req && !fetch_force) || ((state_q == LOCK_WAIT) && data_req);
    go_instr = (state_q == IDLE) && instr_read_i && !go_data;
  end
  // next state: grants first, then completion, then lock release
  always_comb begin
    state_d = state_q;
    if (go_data) state_d = GRANT_DATA;
    else if (go_instr) state_d = GRANT_INSTR;
    else if (done) state_d = (state_q == GRANT_DATA && data_lock_i && !tmo_fire) ? LOCK_WAIT : IDLE;
    else if (state_q == LOCK_WAIT && !data_lock_i) state_d = IDLE;
  end
  // captured transfer, starvation counter and timeout counter next values
  always_comb begin
    addr_d = go_data ? data_address_i : go_instr ? instr_address_i : addr_q;
    wdata_d = go_data ? data_write_data_i : go_instr ? 32'h0 : wdata_q;
    we_d = go_data ? data_write_i : go_instr ? 1'b0 : we_q;
    burst_d = (go_instr || (state_q == IDLE && !instr_read_i)) ? '0 :
              (go_data && instr_read_i && burst_q < BURST_MAX) ? burst_q + 1'b1 : burst_q;
    tmo_d = (go_data || go_instr) ? '0 : (in_grant && !mem_response_i) ? tmo_q + 1'b1 : tmo_q;
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      burst_q <= '0;
      tmo_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      tmo_q <= tmo_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
    end
  end
  // bus strobes from state, responses routed combinationally to the owner
  always_comb begin
    mem_read_o = in_grant && !we_q;
    mem_write_o = in_grant && we_q;
    mem_address_o = addr_q;
    mem_write_data_o = wdata_q;
    grant_o = (state_q == GRANT_INSTR) ? 2'b01 : (state_q == GRANT_DATA || state_q == LOCK_WAIT) ? 2'b10 : 2'b00;
    instr_response_o = done && (state_q == GRANT_INSTR);
    instr_error_o = tmo_fire && (state_q == GRANT_INSTR);
    instr_read_data_o = (state_q == GRANT_INSTR && mem_response_i) ? mem_read_data_i : 32'h0;
    data_response_o = done && (state_q == GRANT_DATA);
    data_error_o = tmo_fire && (state_q == GRANT_DATA);
    data_read_data_o = (state_q == GRANT_DATA && mem_response_i) ? mem_read_data_i : 32'h0;
  end
endmodule
